// File: rtl/hazard_scoreboard.sv
// Tracks in-flight writers beside ID/EX, raises a load-use/RAW stall and selects EXE forwarding paths.
// Latency: hazard and selects are combinational, slots advance one stage per unfrozen edge.
// Backpressure: freeze holds every slot and the stall counter; hazard stalls IF/ID and bubbles EXE.
module hazard_scoreboard #(
  parameter int REG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic             flush,
  input  logic             fwd_en,
  input  logic [REG_W-1:0] id_src_1,
  input  logic [REG_W-1:0] id_src_2,
  input  logic             id_src_1_used,
  input  logic             id_src_2_used,
  input  logic [REG_W-1:0] id_dest,
  input  logic             id_wb_en,
  input  logic             id_mem_r_en,
  output logic             hazard,
  output logic [1:0]       sel_src_1,
  output logic [1:0]       sel_src_2,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic [REG_W-1:0] dest;
    logic             wb_en;
    logic             mem_r_en;
    logic [REG_W-1:0] src_1;
    logic [REG_W-1:0] src_2;
    logic             src_1_used;
    logic             src_2_used;
  } exe_slot_t;

  // The load flag only matters for load-use in EXE, so later slots keep just the writer fields.
  typedef struct packed {
    logic [REG_W-1:0] dest;
    logic             wb_en;
  } wr_slot_t;

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_WB  = 2'b10;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  exe_slot_t exe_slot;
  wr_slot_t  mem_slot;
  wr_slot_t  wb_slot;

  function automatic logic match(input logic [REG_W-1:0] src, input logic used,
                                 input logic [REG_W-1:0] dest, input logic wb_en);
    return used && wb_en && (src == dest);
  endfunction

  logic exe_hit;
  logic mem_hit;

  always_comb begin
    exe_hit = match(id_src_1, id_src_1_used, exe_slot.dest, exe_slot.wb_en) ||
              match(id_src_2, id_src_2_used, exe_slot.dest, exe_slot.wb_en);
    mem_hit = match(id_src_1, id_src_1_used, mem_slot.dest, mem_slot.wb_en) ||
              match(id_src_2, id_src_2_used, mem_slot.dest, mem_slot.wb_en);
    hazard  = 1'b0;
    if (!flush) begin
      if (fwd_en) hazard = exe_hit && exe_slot.mem_r_en;
      else        hazard = exe_hit || mem_hit;
    end
  end

  always_comb begin
    sel_src_1 = SEL_RF;
    sel_src_2 = SEL_RF;
    if (fwd_en) begin
      if (match(exe_slot.src_1, exe_slot.src_1_used, mem_slot.dest, mem_slot.wb_en))
        sel_src_1 = SEL_MEM;
      else if (match(exe_slot.src_1, exe_slot.src_1_used, wb_slot.dest, wb_slot.wb_en))
        sel_src_1 = SEL_WB;
      if (match(exe_slot.src_2, exe_slot.src_2_used, mem_slot.dest, mem_slot.wb_en))
        sel_src_2 = SEL_MEM;
      else if (match(exe_slot.src_2, exe_slot.src_2_used, wb_slot.dest, wb_slot.wb_en))
        sel_src_2 = SEL_WB;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exe_slot  <= '0;
      mem_slot  <= '0;
      wb_slot   <= '0;
      stall_cnt <= '0;
    end else if (!freeze) begin
      wb_slot  <= mem_slot;
      mem_slot <= '{dest: exe_slot.dest, wb_en: exe_slot.wb_en};
      if (flush || hazard) begin
        exe_slot <= '0;
      end else begin
        exe_slot <= '{dest: id_dest, wb_en: id_wb_en, mem_r_en: id_mem_r_en,
                      src_1: id_src_1, src_2: id_src_2,
                      src_1_used: id_src_1_used, src_2_used: id_src_2_used};
      end
      if (hazard && (stall_cnt != CNT_MAX))
        stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomised and directed bench for hazard_scoreboard with an in-flight instruction list model.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic       freeze, flush, fwd_en;
  logic [3:0] id_src_1, id_src_2, id_dest;
  logic       id_src_1_used, id_src_2_used, id_wb_en, id_mem_r_en;
  logic       hazard, hazard_s;
  logic [1:0] sel_src_1, sel_src_2, sel_src_1_s, sel_src_2_s;
  logic [15:0] stall_cnt;
  logic [2:0]  stall_cnt_s;

  always #5 clk = ~clk;

  hazard_scoreboard u_dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .fwd_en(fwd_en),
    .id_src_1(id_src_1), .id_src_2(id_src_2),
    .id_src_1_used(id_src_1_used), .id_src_2_used(id_src_2_used),
    .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en),
    .hazard(hazard), .sel_src_1(sel_src_1), .sel_src_2(sel_src_2), .stall_cnt(stall_cnt)
  );

  // Narrow counter copy so saturation is reachable in a short run.
  hazard_scoreboard #(.REG_W(4), .CNT_W(3)) u_sat (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .fwd_en(fwd_en),
    .id_src_1(id_src_1), .id_src_2(id_src_2),
    .id_src_1_used(id_src_1_used), .id_src_2_used(id_src_2_used),
    .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en),
    .hazard(hazard_s), .sel_src_1(sel_src_1_s), .sel_src_2(sel_src_2_s), .stall_cnt(stall_cnt_s)
  );

  typedef struct {
    int dest; bit wb; bit ld;
    int s1; int s2; bit u1; bit u2;
  } rec_t;

  typedef struct {
    bit hz; int s1; int s2; int c16; int c3;
  } exp_t;

  rec_t pipe[3];          // in-flight instructions: 0 = EXE, 1 = MEM, 2 = WB
  int   cnt16, cnt3;
  exp_t expq[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp_v);
    n_chk++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
    end
  endtask

  function automatic bit writes(input int src, input bit used, input rec_t r);
    return used && r.wb && (src == r.dest);
  endfunction

  function automatic bit m_hazard();
    bit in_exe, in_mem;
    if (flush) return 1'b0;
    in_exe = writes(int'(id_src_1), id_src_1_used, pipe[0]) || writes(int'(id_src_2), id_src_2_used, pipe[0]);
    in_mem = writes(int'(id_src_1), id_src_1_used, pipe[1]) || writes(int'(id_src_2), id_src_2_used, pipe[1]);
    return fwd_en ? (in_exe && pipe[0].ld) : (in_exe || in_mem);
  endfunction

  function automatic int m_sel(input int src, input bit used);
    if (!fwd_en) return 0;
    if (writes(src, used, pipe[1])) return 1;
    if (writes(src, used, pipe[2])) return 2;
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) pipe[i] = '{default: 0};
    cnt16 = 0;
    cnt3  = 0;
  endtask

  task automatic model_advance();
    bit h;
    if (freeze) return;
    h = m_hazard();
    if (h) begin
      if (cnt16 < 65535) cnt16++;
      if (cnt3 < 7) cnt3++;
    end
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    if (flush || h) pipe[0] = '{default: 0};
    else pipe[0] = '{dest: int'(id_dest), wb: id_wb_en, ld: id_mem_r_en,
                     s1: int'(id_src_1), s2: int'(id_src_2), u1: id_src_1_used, u2: id_src_2_used};
  endtask

  task automatic set_id(input int s1, input bit u1, input int s2, input bit u2,
                        input int d, input bit wb, input bit ld);
    id_src_1 = 4'(s1); id_src_1_used = u1;
    id_src_2 = 4'(s2); id_src_2_used = u2;
    id_dest  = 4'(d);  id_wb_en = wb; id_mem_r_en = ld;
  endtask

  task automatic idle();
    set_id(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Called just after a rising edge: queue this cycle's expectation, then take the edge.
  task automatic cycle();
    exp_t e;
    e.hz  = m_hazard();
    e.s1  = m_sel(pipe[0].s1, pipe[0].u1);
    e.s2  = m_sel(pipe[0].s2, pipe[0].u2);
    e.c16 = cnt16;
    e.c3  = cnt3;
    expq.push_back(e);
    @(posedge clk);
    model_advance();
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      chk("hazard",      int'(hazard),      int'(e.hz));
      chk("sel_src_1",   int'(sel_src_1),   e.s1);
      chk("sel_src_2",   int'(sel_src_2),   e.s2);
      chk("stall_cnt",   int'(stall_cnt),   e.c16);
      chk("sat_cnt",     int'(stall_cnt_s), e.c3);
      chk("sat_hazard",  int'(hazard_s),    int'(e.hz));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    rst = 1'b1; freeze = 1'b0; flush = 1'b0; fwd_en = 1'b0;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hazard", int'(hazard), 0);
    chk("rst_sel", int'({sel_src_1, sel_src_2}), 0);
    chk("rst_cnt", int'(stall_cnt), 0);
    rst = 1'b0;
    repeat (5) cycle();

    // No forwarding: writer directly ahead stalls the reader for two cycles.
    c0 = cnt16;
    set_id(0, 0, 0, 0, 3, 1, 0); cycle();
    set_id(3, 1, 0, 0, 4, 1, 0); repeat (3) cycle();
    idle(); repeat (3) cycle();
    chk("nofwd_stalls", int'(stall_cnt) - c0, 2);

    // One independent instruction in between leaves a single stall.
    c0 = int'(stall_cnt);
    set_id(0, 0, 0, 0, 8, 1, 0); cycle();
    set_id(1, 1, 2, 1, 9, 1, 0); cycle();
    set_id(8, 1, 0, 0, 10, 1, 0); repeat (2) cycle();
    idle(); repeat (3) cycle();
    chk("nofwd_gap_stalls", int'(stall_cnt) - c0, 1);

    // Load-use with forwarding: one stall, consumer then sees the load in WB.
    fwd_en = 1'b1;
    c0 = int'(stall_cnt);
    set_id(0, 0, 0, 0, 5, 1, 1); cycle();
    set_id(0, 0, 5, 1, 6, 1, 0); repeat (2) cycle();
    idle();
    chk("ldu_sel2", int'(sel_src_2), 2);
    repeat (3) cycle();
    chk("ldu_stalls", int'(stall_cnt) - c0, 1);

    // ALU result forwarded from MEM to both operands, no stall.
    set_id(0, 0, 0, 0, 2, 1, 0); cycle();
    set_id(2, 1, 2, 1, 7, 1, 0); cycle();
    idle();
    chk("alu_hazard", int'(hazard), 0);
    chk("alu_sel", int'({sel_src_1, sel_src_2}), 5);
    repeat (3) cycle();

    // Two writers of R6 in flight: the younger one in MEM wins.
    set_id(0, 0, 0, 0, 6, 1, 0); cycle();
    set_id(0, 0, 0, 0, 6, 1, 0); cycle();
    set_id(6, 1, 0, 0, 1, 1, 0); cycle();
    idle();
    chk("mem_wins_sel1", int'(sel_src_1), 1);
    repeat (3) cycle();

    // Flush on a pending load-use: no hazard, bubble in EXE, following reader is clean.
    set_id(0, 0, 0, 0, 4, 1, 1); cycle();
    set_id(4, 1, 0, 0, 3, 1, 0); flush = 1'b1;
    #1 chk("flush_hazard", int'(hazard), 0);
    cycle();
    flush = 1'b0;
    #1 chk("after_flush_hazard", int'(hazard), 0);
    cycle();
    idle(); repeat (3) cycle();

    // Freeze in the middle of a stall holds everything.
    fwd_en = 1'b0;
    set_id(0, 0, 0, 0, 7, 1, 0); cycle();
    set_id(0, 0, 7, 1, 1, 1, 0); cycle();
    c0 = int'(stall_cnt);
    freeze = 1'b1; repeat (3) cycle();
    chk("freeze_hold_cnt", int'(stall_cnt), c0);
    chk("freeze_hold_hazard", int'(hazard), 1);
    freeze = 1'b0; repeat (2) cycle();
    idle(); repeat (3) cycle();

    // Reset mid-stall drops hazard at once and clears the counter.
    set_id(0, 0, 0, 0, 1, 1, 0); cycle();
    set_id(1, 1, 0, 0, 2, 1, 0);
    #1 chk("pre_rst_hazard", int'(hazard), int'(m_hazard()));
    rst = 1'b1;
    #1;
    chk("midrst_hazard", int'(hazard), 0);
    chk("midrst_cnt", int'(stall_cnt), 0);
    chk("midrst_sat_cnt", int'(stall_cnt_s), 0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    idle(); cycle();

    // Drive the narrow counter past its ceiling.
    for (int k = 0; k < 5; k++) begin
      set_id(0, 0, 0, 0, 9, 1, 0); cycle();
      set_id(9, 1, 9, 1, 0, 0, 0); repeat (3) cycle();
    end
    idle(); cycle();
    chk("sat_ceiling", int'(stall_cnt_s), 7);
    chk("wide_cnt", int'(stall_cnt), 10);

    // Random traffic over a small register window to provoke dependencies.
    for (int n = 0; n < 1500; n++) begin
      fwd_en = ($urandom_range(0, 3) != 0);
      freeze = ($urandom_range(0, 9) == 0);
      flush  = ($urandom_range(0, 9) == 0);
      set_id($urandom_range(0, 3), 1'($urandom_range(0, 1)),
             $urandom_range(0, 3), 1'($urandom_range(0, 1)),
             $urandom_range(0, 3), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0));
      cycle();
    end
    freeze = 1'b0; flush = 1'b0; idle();
    cycle();
    @(negedge clk); #1;
    chk("queue_drained", expq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
